// File: rtl/mux8way_arbiter.sv
// Eight-channel valid/ready collector into one registered output word tagged with its source index.
// Latency: one cycle input-to-output; sustains one word per cycle when out_ready stays high.
// Backpressure: all in_ready low while the output is full and stalled; MUX8WAY_FIXED_PRIORITY_EN selects fixed priority.
module mux8way_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_valid,
    input  logic [8*WIDTH-1:0]   in_data,
    output logic [7:0]           in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       search_base;
    logic [2:0]       idx;
    logic [2:0]       win;
    logic             found;
    logic             can_load;
    logic             load;

`ifdef MUX8WAY_FIXED_PRIORITY_EN
    assign search_base = 3'd0;
`else
    logic [2:0] ptr_q, ptr_d;

    // Next search starts just past the last winner so every requester gets a turn.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = win + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign search_base = ptr_q;
`endif

    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = search_base + 3'(i);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign can_load = (state_q == EMPTY) || out_ready;
    assign load     = can_load && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // A drain without a refill leaves the last word and tag in place.
    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        if (load) begin
            data_d = in_data[int'(win)*WIDTH +: WIDTH];
            sel_d  = win;
        end
    end

    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_sel   = sel_q;
        in_ready  = load ? (8'd1 << win) : 8'd0;
    end

endmodule

// File: tb/tb_mux8way_arbiter.sv
// Bench for mux8way_arbiter: directed scenarios plus a randomized run against a queue-free cycle model.
module tb_mux8way_arbiter;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;

    int errors = 0;
    int checks = 0;

    mux8way_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    function automatic logic [W-1:0] get_ch(input logic [8*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    // Winner = valid channel at the smallest circular distance from the start point.
    function automatic int pick(input logic [7:0] v, input int start);
        int best = -1;
        int bd = 99;
        for (int k = 0; k < 8; k++) begin
            if (v[k] && (((k - start) + 8) % 8) < bd) begin
                bd = ((k - start) + 8) % 8;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic apply_reset();
        in_valid = 8'h00;
        in_data = '0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h s=%0d r=%h want 0 0000 0 00", out_valid, out_data, out_sel, in_ready);
        end
        checks++;
        in_valid = 8'h01;
        set_ch(0, 16'hAAAA);
        tick();
        in_valid = 8'h00;
        if (out_valid !== 1'b1 || out_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL reset_preload: got v=%b d=%h want 1 aaaa", out_valid, out_data);
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%h s=%0d want 0 0000 0", out_valid, out_data, out_sel);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        in_valid = 8'h01;
        out_ready = 1'b1;
        set_ch(0, 16'h0F0F);
        #1;
        if (in_ready !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_grant_ready: got %h want 01", in_ready);
        end
        checks++;
        tick();
        in_valid = 8'h00;
        if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 16'h0F0F) begin
            errors++;
            $display("FAIL reset_first_grant: got v=%b s=%0d d=%h want 1 0 0f0f", out_valid, out_sel, out_data);
        end
        checks++;
    endtask

    task automatic test_single();
        apply_reset();
        in_valid = 8'b0010_0000;
        set_ch(5, 16'hBEEF);
        out_ready = 1'b1;
        #1;
        if (in_ready !== 8'b0010_0000) begin
            errors++;
            $display("FAIL single_ready: got %b want 00100000", in_ready);
        end
        checks++;
        tick();
        in_valid = 8'h00;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 3'b101) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h s=%0d want 1 beef 5", out_valid, out_data, out_sel);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        int exp;
        apply_reset();
        for (int k = 0; k < 8; k++) set_ch(k, 16'h0100 + 16'(k));
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
`ifdef MUX8WAY_FIXED_PRIORITY_EN
            exp = 0;
`else
            exp = i % 8;
`endif
            #1;
            if (in_ready !== (8'd1 << exp)) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %h want %h", i, in_ready, 8'd1 << exp);
            end
            checks++;
            tick();
            if (out_valid !== 1'b1 || out_sel !== 3'(exp) || out_data !== 16'h0100 + 16'(exp)) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want 1 %0d %h", i, out_valid, out_sel, out_data, exp, 16'h0100 + 16'(exp));
            end
            checks++;
        end
        in_valid = 8'h00;
    endtask

    task automatic test_backpressure();
        int exp;
        apply_reset();
        in_valid = 8'b0000_1000;
        set_ch(3, 16'h1234);
        tick();
        for (int k = 0; k < 8; k++) set_ch(k, 16'hA0A0 + 16'(k));
        in_valid = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== 16'h1234 || out_sel !== 3'd3) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got r=%h v=%b d=%h s=%0d want 00 1 1234 3", i, in_ready, out_valid, out_data, out_sel);
            end
            checks++;
            tick();
        end
`ifdef MUX8WAY_FIXED_PRIORITY_EN
        exp = 0;
`else
        exp = 4;
`endif
        out_ready = 1'b1;
        #1;
        if (in_ready !== (8'd1 << exp)) begin
            errors++;
            $display("FAIL bp_release_ready: got %h want %h", in_ready, 8'd1 << exp);
        end
        checks++;
        tick();
        in_valid = 8'h00;
        if (out_valid !== 1'b1 || out_sel !== 3'(exp) || out_data !== 16'hA0A0 + 16'(exp)) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b s=%0d d=%h want 1 %0d %h", out_valid, out_sel, out_data, exp, 16'hA0A0 + 16'(exp));
        end
        checks++;
    endtask

    task automatic test_wrap();
        int exp2;
        apply_reset();
        set_ch(7, 16'h7777);
        set_ch(0, 16'h0000);
        in_valid = 8'b1000_0000;
        out_ready = 1'b1;
        tick();
        in_valid = 8'b1000_0001;
        #1;
        if (in_ready !== 8'h01) begin
            errors++;
            $display("FAIL wrap_ready0: got %h want 01", in_ready);
        end
        checks++;
        tick();
        if (out_sel !== 3'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_grant0: got s=%0d v=%b want 0 1", out_sel, out_valid);
        end
        checks++;
`ifdef MUX8WAY_FIXED_PRIORITY_EN
        exp2 = 0;
`else
        exp2 = 7;
`endif
        tick();
        in_valid = 8'h00;
        if (out_sel !== 3'(exp2) || out_data !== (exp2 == 7 ? 16'h7777 : 16'h0000)) begin
            errors++;
            $display("FAIL wrap_grant7: got s=%0d d=%h want %0d", out_sel, out_data, exp2);
        end
        checks++;
    endtask

    task automatic test_drain();
        apply_reset();
        set_ch(2, 16'h5A5A);
        in_valid = 8'b0000_0100;
        out_ready = 1'b1;
        tick();
        in_valid = 8'h00;
        #1;
        if (out_valid !== 1'b1 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL drain_full: got v=%b r=%h want 1 00", out_valid, in_ready);
        end
        checks++;
        tick();
        if (out_valid !== 1'b0 || out_data !== 16'h5A5A || out_sel !== 3'd2) begin
            errors++;
            $display("FAIL drain_empty: got v=%b d=%h s=%0d want 0 5a5a 2", out_valid, out_data, out_sel);
        end
        checks++;
    endtask

    task automatic test_random();
        logic         m_full;
        logic [W-1:0] m_data;
        int           m_sel;
        int           m_ptr;
        int           w;
        logic [7:0]   exp_rdy;
        apply_reset();
        m_full = 1'b0;
        m_data = '0;
        m_sel = 0;
        m_ptr = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid = (c % 3 == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            for (int k = 0; k < 8; k++) set_ch(k, 16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = pick(in_valid, m_ptr);
            exp_rdy = ((!m_full || out_ready) && w >= 0) ? (8'd1 << w) : 8'h00;
            if (in_ready !== exp_rdy || out_valid !== m_full || out_data !== m_data || out_sel !== 3'(m_sel)) begin
                errors++;
                $display("FAIL random[%0d]: got r=%h v=%b d=%h s=%0d want r=%h v=%b d=%h s=%0d",
                         c, in_ready, out_valid, out_data, out_sel, exp_rdy, m_full, m_data, m_sel);
            end
            checks++;
            if (exp_rdy != 8'h00) begin
                m_full = 1'b1;
                m_data = get_ch(in_data, w);
                m_sel = w;
`ifndef MUX8WAY_FIXED_PRIORITY_EN
                m_ptr = (w + 1) % 8;
`endif
            end else if (out_ready) begin
                m_full = 1'b0;
            end
            tick();
        end
        in_valid = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 8'h00;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
